// File: rtl/ysyx_22050854_dcache_wb.sv
// rtl/ysyx_22050854_dcache_wb.sv - N-way write-back/write-allocate blocking L1 data cache
//
// Purpose: blocking set-associative data cache between the load/store unit
// and the AXI bridge. One request is in flight at a time. Misses pick a victim
// (lowest invalid way, else the per-set round-robin way). A dirty victim is
// written back as a whole line before the refill burst of 64-bit beats. After
// the refill the request is replayed through LOOKUP, so a write miss merges
// on the replay.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid/i_op/i_index/i_tag/  CPU request (op 1 = write); i_offset[2:0]
//   i_offset/i_wstrb/i_wdata     is ignored because accesses are doubleword-aligned
//   o_addr_ok, o_data_ok, o_rdata  accept / complete / read data
//   o_rd_req/o_rd_type/o_rd_addr, i_rd_rdy            line read request
//   i_ret_valid/i_ret_last/i_ret_data                 refill beats
//   o_wr_req/o_wr_type/o_wr_addr/o_wr_wstrb/o_wr_data, i_wr_rdy  write-back
module ysyx_22050854_dcache_wb #(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 7,
  parameter int WAYS        = 2,
  localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic                          i_op,
  input  logic [INDEX_BITS-1:0]         i_index,
  input  logic [TAG_BITS-1:0]           i_tag,
  input  logic [OFFSET_BITS-1:0]        i_offset,
  input  logic [7:0]                    i_wstrb,
  input  logic [63:0]                   i_wdata,
  output logic                          o_addr_ok,
  output logic                          o_data_ok,
  output logic [63:0]                   o_rdata,
  output logic                          o_rd_req,
  output logic [2:0]                    o_rd_type,
  output logic [31:0]                   o_rd_addr,
  input  logic                          i_rd_rdy,
  input  logic                          i_ret_valid,
  input  logic                          i_ret_last,
  input  logic [63:0]                   i_ret_data,
  output logic                          o_wr_req,
  output logic [2:0]                    o_wr_type,
  output logic [31:0]                   o_wr_addr,
  output logic [7:0]                    o_wr_wstrb,
  output logic [8*(2**OFFSET_BITS)-1:0] o_wr_data,
  input  logic                          i_wr_rdy
);

  localparam int BEATS    = (2**OFFSET_BITS) / 8;
  localparam int LINE_W   = 8 * (2**OFFSET_BITS);
  localparam int SETS     = 2**INDEX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DW_BITS  = OFFSET_BITS - 3;
  localparam int CNT_BITS = DW_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_MISS, S_REFILL
  } state_t;

  state_t r_state, w_next;

  // Line data and tags are never reset; valid/dirty/pointer are.
  logic [LINE_W-1:0]   r_line  [WAYS][SETS];
  logic [TAG_BITS-1:0] r_tagv  [WAYS][SETS];
  logic [WAYS-1:0]     r_vld   [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  logic [WAY_BITS-1:0] r_rr    [SETS];

  // Latched request and miss bookkeeping
  logic                  r_op;
  logic [INDEX_BITS-1:0] r_index;
  logic [TAG_BITS-1:0]   r_tag;
  logic [DW_BITS-1:0]    r_dw;
  logic [7:0]            r_wstrb;
  logic [63:0]           r_wdata;
  logic [WAY_BITS-1:0]   r_victim;
  logic                  r_by_ptr;
  logic [CNT_BITS-1:0]   r_cnt;

  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit;
  logic [WAY_BITS-1:0] w_hit_way;
  logic                w_has_free;
  logic [WAY_BITS-1:0] w_free_way;
  logic [WAY_BITS-1:0] w_victim;
  logic                w_victim_dirty;
  logic [LINE_W-1:0]   w_hit_line;
  logic [63:0]         w_hit_word;
  logic [63:0]         w_merged_word;
  logic [LINE_W-1:0]   w_merged_line;
  logic                w_wr_hit;
  logic                w_refill_beat;
  logic                w_refill_done;
  logic                w_unused;

  assign w_unused = ^i_offset[2:0];

  // Tag match and victim search for the latched set.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_vld[r_index][w] && (r_tagv[w][r_index] == r_tag);
      if (w_hit_vec[w]) w_hit_way = WAY_BITS'(w);
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_vld[r_index][w]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_BITS'(w);
      end
    end
  end

  assign w_hit          = |w_hit_vec;
  assign w_victim       = w_has_free ? w_free_way : r_rr[r_index];
  assign w_victim_dirty = r_vld[r_index][w_victim] && r_dirty[r_index][w_victim];
  assign w_hit_line     = r_line[w_hit_way][r_index];
  assign w_hit_word     = w_hit_line[{r_dw, 6'b0} +: 64];

  always_comb begin
    w_merged_word = w_hit_word;
    for (int b = 0; b < 8; b++) begin
      if (r_wstrb[b]) w_merged_word[b*8 +: 8] = r_wdata[b*8 +: 8];
    end
    w_merged_line = w_hit_line;
    w_merged_line[{r_dw, 6'b0} +: 64] = w_merged_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_addr_ok = 1'b0;
    o_data_ok = 1'b0;
    o_rd_req  = 1'b0;
    o_wr_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_addr_ok = 1'b1;
        if (i_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          o_data_ok = 1'b1;
          w_next    = S_IDLE;
        end else if (w_victim_dirty) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_MISS;
        end
      end
      // The whole line moves in the single cycle the bus is ready.
      S_WRITEBACK: begin
        o_wr_req = i_wr_rdy;
        if (i_wr_rdy) w_next = S_MISS;
      end
      S_MISS: begin
        o_rd_req = 1'b1;
        if (i_rd_rdy) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (i_ret_valid && i_ret_last) w_next = S_LOOKUP;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset silences every handshake, including a request caught mid-flight.
    if (i_rst) begin
      o_addr_ok = 1'b0;
      o_data_ok = 1'b0;
      o_rd_req  = 1'b0;
      o_wr_req  = 1'b0;
      w_next    = S_IDLE;
    end
  end

  assign w_wr_hit      = o_data_ok && r_op;
  assign w_refill_beat = (r_state == S_REFILL) && i_ret_valid && !i_rst;
  assign w_refill_done = w_refill_beat && i_ret_last;

  assign o_rdata    = (o_data_ok && !r_op) ? w_hit_word : 64'd0;
  assign o_rd_type  = 3'b100;
  assign o_rd_addr  = {r_tag, r_index, {OFFSET_BITS{1'b0}}};
  assign o_wr_type  = 3'b100;
  assign o_wr_wstrb = 8'hFF;
  assign o_wr_addr  = {r_tagv[r_victim][r_index], r_index, {OFFSET_BITS{1'b0}}};
  assign o_wr_data  = r_line[r_victim][r_index];

  // Per-line state bits and replacement pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_vld[s]   <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (w_wr_hit) r_dirty[r_index][w_hit_way] <= 1'b1;
      if (w_refill_done) begin
        r_vld[r_index][r_victim]   <= 1'b1;
        r_dirty[r_index][r_victim] <= 1'b0;
        // Pointer only advances when it actually chose the victim.
        if (r_by_ptr) begin
          r_rr[r_index] <= (r_rr[r_index] == WAY_BITS'(WAYS - 1)) ? '0
                                                                   : r_rr[r_index] + 1'b1;
        end
      end
    end
  end

  // Request latch, victim capture and data/tag array writes.
  always_ff @(posedge i_clk) begin
    if (o_addr_ok && i_valid) begin
      r_op    <= i_op;
      r_index <= i_index;
      r_tag   <= i_tag;
      r_dw    <= i_offset[OFFSET_BITS-1:3];
      r_wstrb <= i_wstrb;
      r_wdata <= i_wdata;
    end
    if (r_state == S_LOOKUP && !w_hit) begin
      r_victim <= w_victim;
      r_by_ptr <= !w_has_free;
    end
    // Counter saturates at BEATS so surplus beats without ret_last are dropped.
    if (r_state == S_MISS && i_rd_rdy) begin
      r_cnt <= '0;
    end else if (w_refill_beat && r_cnt < CNT_BITS'(BEATS)) begin
      r_cnt <= r_cnt + 1'b1;
    end
    if (w_wr_hit) r_line[w_hit_way][r_index] <= w_merged_line;
    if (w_refill_beat && r_cnt < CNT_BITS'(BEATS)) begin
      r_line[r_victim][r_index][{r_cnt[DW_BITS-1:0], 6'b0} +: 64] <= i_ret_data;
    end
    if (w_refill_done) r_tagv[r_victim][r_index] <= r_tag;
  end

endmodule

// File: tb/tb_ysyx_22050854_dcache_wb.sv
// tb/tb_ysyx_22050854_dcache_wb.sv - scoreboard bench for ysyx_22050854_dcache_wb
module tb_ysyx_22050854_dcache_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic rst;

  // DUT A: defaults (16-byte lines, 128 sets, 2 ways)
  logic a_valid, a_op; logic [6:0] a_index; logic [20:0] a_tag; logic [3:0] a_offset;
  logic [7:0] a_wstrb; logic [63:0] a_wdata;
  logic a_addr_ok, a_data_ok; logic [63:0] a_rdata;
  logic a_rd_req; logic [2:0] a_rd_type; logic [31:0] a_rd_addr;
  logic a_rd_rdy, a_ret_valid, a_ret_last; logic [63:0] a_ret_data;
  logic a_wr_req; logic [2:0] a_wr_type; logic [31:0] a_wr_addr; logic [7:0] a_wr_wstrb;
  logic [127:0] a_wr_data; logic a_wr_rdy;

  ysyx_22050854_dcache_wb #(.OFFSET_BITS(4), .INDEX_BITS(7), .WAYS(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_op(a_op), .i_index(a_index),
    .i_tag(a_tag), .i_offset(a_offset), .i_wstrb(a_wstrb), .i_wdata(a_wdata),
    .o_addr_ok(a_addr_ok), .o_data_ok(a_data_ok), .o_rdata(a_rdata),
    .o_rd_req(a_rd_req), .o_rd_type(a_rd_type), .o_rd_addr(a_rd_addr), .i_rd_rdy(a_rd_rdy),
    .i_ret_valid(a_ret_valid), .i_ret_last(a_ret_last), .i_ret_data(a_ret_data),
    .o_wr_req(a_wr_req), .o_wr_type(a_wr_type), .o_wr_addr(a_wr_addr),
    .o_wr_wstrb(a_wr_wstrb), .o_wr_data(a_wr_data), .i_wr_rdy(a_wr_rdy));

  // DUT B: 32-byte lines, direct mapped
  logic b_valid, b_op; logic [6:0] b_index; logic [19:0] b_tag; logic [4:0] b_offset;
  logic [7:0] b_wstrb; logic [63:0] b_wdata;
  logic b_addr_ok, b_data_ok; logic [63:0] b_rdata;
  logic b_rd_req; logic [2:0] b_rd_type; logic [31:0] b_rd_addr;
  logic b_rd_rdy, b_ret_valid, b_ret_last; logic [63:0] b_ret_data;
  logic b_wr_req; logic [2:0] b_wr_type; logic [31:0] b_wr_addr; logic [7:0] b_wr_wstrb;
  logic [255:0] b_wr_data; logic b_wr_rdy;

  ysyx_22050854_dcache_wb #(.OFFSET_BITS(5), .INDEX_BITS(7), .WAYS(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_op(b_op), .i_index(b_index),
    .i_tag(b_tag), .i_offset(b_offset), .i_wstrb(b_wstrb), .i_wdata(b_wdata),
    .o_addr_ok(b_addr_ok), .o_data_ok(b_data_ok), .o_rdata(b_rdata),
    .o_rd_req(b_rd_req), .o_rd_type(b_rd_type), .o_rd_addr(b_rd_addr), .i_rd_rdy(b_rd_rdy),
    .i_ret_valid(b_ret_valid), .i_ret_last(b_ret_last), .i_ret_data(b_ret_data),
    .o_wr_req(b_wr_req), .o_wr_type(b_wr_type), .o_wr_addr(b_wr_addr),
    .o_wr_wstrb(b_wr_wstrb), .o_wr_data(b_wr_data), .i_wr_rdy(b_wr_rdy));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic a_issue(input logic op_i, input logic [31:0] addr, input logic [7:0] ws,
                         input logic [63:0] wd);
    a_valid = 1'b1; a_op = op_i; a_offset = addr[3:0]; a_index = addr[10:4];
    a_tag = addr[31:11]; a_wstrb = ws; a_wdata = wd;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic b_issue(input logic op_i, input logic [31:0] addr, input logic [7:0] ws,
                         input logic [63:0] wd);
    b_valid = 1'b1; b_op = op_i; b_offset = addr[4:0]; b_index = addr[11:5];
    b_tag = addr[31:12]; b_wstrb = ws; b_wdata = wd;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic a_wait_data(input int budget, output bit got, output int cyc, output logic [63:0] rd);
    got = 1'b0; cyc = 0; rd = '0;
    while (!got && cyc <= budget) begin
      if (a_data_ok) begin got = 1'b1; rd = a_rdata; end
      else begin cyc++; @(negedge clk); end
    end
  endtask

  task automatic b_wait_data(input int budget, output bit got, output int cyc, output logic [63:0] rd);
    got = 1'b0; cyc = 0; rd = '0;
    while (!got && cyc <= budget) begin
      if (b_data_ok) begin got = 1'b1; rd = b_rdata; end
      else begin cyc++; @(negedge clk); end
    end
  endtask

  task automatic a_wait_rd(input int budget, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    while (!got && cyc <= budget) begin
      if (a_rd_req) got = 1'b1;
      else begin cyc++; @(negedge clk); end
    end
  endtask

  task automatic b_wait_rd(input int budget, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    while (!got && cyc <= budget) begin
      if (b_rd_req) got = 1'b1;
      else begin cyc++; @(negedge clk); end
    end
  endtask

  task automatic a_refill(input logic [63:0] d0, input logic [63:0] d1);
    a_rd_rdy = 1'b1; @(negedge clk); a_rd_rdy = 1'b0;
    a_ret_valid = 1'b1; a_ret_data = d0; a_ret_last = 1'b0; @(negedge clk);
    a_ret_data = d1; a_ret_last = 1'b1; @(negedge clk);
    a_ret_valid = 1'b0; a_ret_last = 1'b0;
  endtask

  task automatic b_refill(input logic [31:0] hi);
    b_rd_rdy = 1'b1; @(negedge clk); b_rd_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_ret_valid = 1'b1; b_ret_data = {hi, 32'(k)}; b_ret_last = (k == 3); @(negedge clk);
    end
    b_ret_valid = 1'b0; b_ret_last = 1'b0;
  endtask

  // ---------------- feature tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_addr_ok !== 1'b0) begin n_bad++; $display("FAIL rst_addr_ok got %b want 0", a_addr_ok); end
    n_cmp++; if ({a_data_ok, a_rd_req, a_wr_req} !== 3'b000) begin n_bad++;
      $display("FAIL rst_outputs got %b want 000", {a_data_ok, a_rd_req, a_wr_req}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_addr_ok !== 1'b1) begin n_bad++; $display("FAIL post_rst_addr_ok got %b want 1", a_addr_ok); end
    n_cmp++; if (a_rdata !== 64'd0) begin n_bad++; $display("FAIL post_rst_rdata got %h want 0", a_rdata); end
    n_cmp++; if (b_addr_ok !== 1'b1) begin n_bad++; $display("FAIL post_rst_b_addr_ok got %b want 1", b_addr_ok); end
  endtask

  task automatic test_read_miss;
    bit got; int cyc; logic [63:0] rd, ex;
    exp_q.push_back(64'h2222222222222222);
    a_issue(1'b0, 32'h80000018, 8'h00, 64'h0);
    a_wait_rd(10, got, cyc);
    n_cmp++; if (!got || cyc != 1) begin n_bad++; $display("FAIL miss_rd_latency got %0d/%0d want 1/1", got, cyc); end
    n_cmp++; if (a_rd_addr !== 32'h80000010) begin n_bad++; $display("FAIL miss_rd_addr got %h want 80000010", a_rd_addr); end
    n_cmp++; if (a_rd_type !== 3'b100) begin n_bad++; $display("FAIL rd_type got %b want 100", a_rd_type); end
    a_refill(64'h1111111111111111, 64'h2222222222222222);
    a_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || cyc != 0) begin n_bad++; $display("FAIL miss_data_ok_latency got %0d/%0d want 1/0", got, cyc); end
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL miss_rdata got %h want %h", rd, ex); end
  endtask

  task automatic test_write_hit;
    bit got; int cyc; logic [63:0] rd, ex;
    @(negedge clk);
    a_issue(1'b1, 32'h80000018, 8'h0F, 64'hAAAABBBBCCCCDDDD);
    a_wait_data(3, got, cyc, rd);
    n_cmp++; if (!got || cyc != 0) begin n_bad++; $display("FAIL wr_hit_latency got %0d/%0d want 1/0", got, cyc); end
    n_cmp++; if ({a_rd_req, a_wr_req, a_addr_ok} !== 3'b000) begin n_bad++;
      $display("FAIL wr_hit_quiet got %b want 000", {a_rd_req, a_wr_req, a_addr_ok}); end
    @(negedge clk);
    exp_q.push_back(64'h22222222CCCCDDDD);
    a_issue(1'b0, 32'h80000018, 8'h00, 64'h0);
    a_wait_data(3, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || cyc != 0) begin n_bad++; $display("FAIL rd_hit_latency got %0d/%0d want 1/0", got, cyc); end
    n_cmp++; if (rd !== ex) begin n_bad++; $display("FAIL rd_after_wr got %h want %h", rd, ex); end
  endtask

  task automatic test_evict;
    bit got, seen, stable; int cyc; logic [63:0] rd, ex;
    @(negedge clk);
    exp_q.push_back(64'h4444444444444444);
    a_issue(1'b0, 32'h80000818, 8'h00, 64'h0);
    a_wait_rd(10, got, cyc);
    n_cmp++; if (!got || a_rd_addr !== 32'h80000810) begin n_bad++; $display("FAIL fill2_rd_addr got %h want 80000810", a_rd_addr); end
    a_refill(64'h3333333333333333, 64'h4444444444444444);
    a_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL fill2_rdata got %h want %h", rd, ex); end
    // Set full: the pointer (way 0) holds the dirty line
    @(negedge clk);
    a_wr_rdy = 1'b0;
    exp_q.push_back(64'h5555555555555555);
    a_issue(1'b0, 32'h80001010, 8'h00, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (a_wr_req || a_rd_req) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL wb_held got req=1 want 0 while wr_rdy low"); end
    a_wr_rdy = 1'b1; #1;
    n_cmp++; if (a_wr_req !== 1'b1) begin n_bad++; $display("FAIL wb_req got %b want 1", a_wr_req); end
    n_cmp++; if (a_wr_addr !== 32'h80000010) begin n_bad++; $display("FAIL wb_addr got %h want 80000010", a_wr_addr); end
    n_cmp++; if (a_wr_data !== {64'h22222222CCCCDDDD, 64'h1111111111111111}) begin n_bad++;
      $display("FAIL wb_data got %h want 22222222ccccdddd1111111111111111", a_wr_data); end
    n_cmp++; if (a_wr_wstrb !== 8'hFF || a_wr_type !== 3'b100) begin n_bad++;
      $display("FAIL wb_consts got %h/%b want ff/100", a_wr_wstrb, a_wr_type); end
    @(negedge clk);
    a_wr_rdy = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!a_rd_req || a_rd_addr !== 32'h80001010) stable = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (!stable || !a_rd_req) begin n_bad++; $display("FAIL rd_req_stable got %b want 1 (addr %h)", stable, a_rd_addr); end
    a_refill(64'h5555555555555555, 64'h6666666666666666);
    a_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL evict_rdata got %h want %h", rd, ex); end
    // Other way survives and still hits
    @(negedge clk);
    exp_q.push_back(64'h4444444444444444);
    a_issue(1'b0, 32'h80000818, 8'h00, 64'h0);
    a_wait_data(2, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || cyc != 0 || rd !== ex) begin n_bad++;
      $display("FAIL survivor_hit got %h (ok=%0d cyc=%0d) want %h", rd, got, cyc, ex); end
    // Pointer advanced to way 1: a new tag evicts the clean way 1 line
    @(negedge clk);
    exp_q.push_back(64'h8888888888888888);
    a_issue(1'b0, 32'h80001818, 8'h00, 64'h0);
    a_wait_rd(10, got, cyc);
    n_cmp++; if (!got || cyc != 1) begin n_bad++; $display("FAIL rr_clean_victim got %0d/%0d want 1/1", got, cyc); end
    a_refill(64'h7777777777777777, 64'h8888888888888888);
    a_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL rr_fill_rdata got %h want %h", rd, ex); end
    @(negedge clk);
    exp_q.push_back(64'h5555555555555555);
    a_issue(1'b0, 32'h80001010, 8'h00, 64'h0);
    a_wait_data(2, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || cyc != 0 || rd !== ex) begin n_bad++;
      $display("FAIL rr_way0_kept got %h (ok=%0d cyc=%0d) want %h", rd, got, cyc, ex); end
  endtask

  task automatic test_reset_mid;
    bit got, seen; int cyc; logic [63:0] rd, ex;
    @(negedge clk);
    a_rd_rdy = 1'b0;
    a_issue(1'b0, 32'h80002020, 8'h00, 64'h0);
    a_wait_rd(10, got, cyc);
    a_rd_rdy = 1'b1; @(negedge clk); a_rd_rdy = 1'b0;
    a_ret_valid = 1'b1; a_ret_data = 64'h9999999999999999; a_ret_last = 1'b0; @(negedge clk);
    a_ret_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    seen = a_data_ok || a_rd_req || a_addr_ok;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (a_data_ok || a_rd_req) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rst_mid_quiet got activity want none"); end
    n_cmp++; if (a_addr_ok !== 1'b1) begin n_bad++; $display("FAIL rst_mid_addr_ok got %b want 1", a_addr_ok); end
    exp_q.push_back(64'hAAAAAAAAAAAAAAAA);
    a_issue(1'b0, 32'h80002020, 8'h00, 64'h0);
    a_wait_rd(10, got, cyc);
    n_cmp++; if (!got || a_rd_addr !== 32'h80002020) begin n_bad++;
      $display("FAIL rst_mid_remiss got %0d/%h want 1/80002020", got, a_rd_addr); end
    a_refill(64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB);
    a_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL rst_mid_rdata got %h want %h", rd, ex); end
  endtask

  task automatic test_wide_line;
    bit got; int cyc; logic [63:0] rd, ex;
    @(negedge clk);
    exp_q.push_back({32'hB0B0B0B0, 32'd3});
    b_issue(1'b0, 32'h80000018, 8'h00, 64'h0);
    b_wait_rd(10, got, cyc);
    n_cmp++; if (!got || b_rd_addr !== 32'h80000000) begin n_bad++; $display("FAIL wide_rd_addr got %h want 80000000", b_rd_addr); end
    b_refill(32'hB0B0B0B0);
    b_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || cyc != 0 || rd !== ex) begin n_bad++; $display("FAIL wide_beat3 got %h want %h", rd, ex); end
    // Write miss allocates, merge happens on replay
    @(negedge clk);
    b_issue(1'b1, 32'h80001008, 8'hF0, 64'h0123456789ABCDEF);
    b_wait_rd(10, got, cyc);
    n_cmp++; if (!got || b_rd_addr !== 32'h80001000) begin n_bad++; $display("FAIL wmiss_rd_addr got %h want 80001000", b_rd_addr); end
    b_refill(32'hC0C0C0C0);
    b_wait_data(5, got, cyc, rd);
    n_cmp++; if (!got || cyc != 0) begin n_bad++; $display("FAIL wmiss_data_ok got %0d/%0d want 1/0", got, cyc); end
    @(negedge clk);
    exp_q.push_back({32'h01234567, 32'd1});
    b_issue(1'b0, 32'h80001008, 8'h00, 64'h0);
    b_wait_data(2, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL wmiss_merge got %h want %h", rd, ex); end
    // Single way dirty: re-reading the first line writes back first
    @(negedge clk);
    exp_q.push_back({32'hB0B0B0B0, 32'd3});
    b_issue(1'b0, 32'h80000018, 8'h00, 64'h0);
    @(negedge clk);
    n_cmp++; if (b_wr_req !== 1'b1 || b_wr_addr !== 32'h80001000) begin n_bad++;
      $display("FAIL wide_wb got req=%b addr=%h want 1/80001000", b_wr_req, b_wr_addr); end
    n_cmp++; if (b_wr_data[127:64] !== {32'h01234567, 32'd1} || b_wr_data[255:192] !== {32'hC0C0C0C0, 32'd3}) begin
      n_bad++; $display("FAIL wide_wb_data got %h want dw1 0123456700000001 dw3 c0c0c0c000000003", b_wr_data); end
    b_wait_rd(5, got, cyc);
    n_cmp++; if (!got || cyc != 1 || b_rd_addr !== 32'h80000000) begin n_bad++;
      $display("FAIL wide_wb_then_rd got %0d/%0d/%h want 1/1/80000000", got, cyc, b_rd_addr); end
    b_refill(32'hB0B0B0B0);
    b_wait_data(5, got, cyc, rd);
    ex = exp_q.pop_front();
    n_cmp++; if (!got || rd !== ex) begin n_bad++; $display("FAIL wide_refetch got %h want %h", rd, ex); end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_index = '0; a_tag = '0; a_offset = '0; a_wstrb = '0; a_wdata = '0;
    a_rd_rdy = 0; a_ret_valid = 0; a_ret_last = 0; a_ret_data = '0; a_wr_rdy = 1'b1;
    b_valid = 0; b_op = 0; b_index = '0; b_tag = '0; b_offset = '0; b_wstrb = '0; b_wdata = '0;
    b_rd_rdy = 0; b_ret_valid = 0; b_ret_last = 0; b_ret_data = '0; b_wr_rdy = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_miss();
    test_write_hit();
    test_evict();
    test_reset_mid();
    test_wide_line();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_dcache_wb.md
# ysyx_22050854_dcache_wb

Parametrised, N-way set-associative, write-back/write-allocate, blocking L1 data cache between the CPU load/store unit and the AXI bridge. It generalises the single-way read-only data-cache interface in three ways: configurable line size, set count and associativity; per-set round-robin replacement; dirty-line write-back over the bus write channel. It serves one request at a time and refills a line as a burst of 64-bit beats.

## Interface
- OFFSET_BITS, 4: log2 line bytes; 4 or more; beats per line BEATS = 2^OFFSET_BITS/8
- INDEX_BITS, 7: log2 sets
- WAYS, 2: associativity; 1, 2 or 4
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS: derived, not overridden
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- valid  in  1  CPU request valid
- op  in  1  1 write, 0 read
- index  in  INDEX_BITS  set select
- tag  in  TAG_BITS  address tag
- offset  in  OFFSET_BITS  byte offset; offset[2:0] ignored (doubleword-aligned)
- wstrb  in  8  byte enables for write
- wdata  in  64  write data
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  request complete this cycle
- rdata  out  64  read doubleword, valid with data_ok on reads
- rd_req  out  1  line read request
- rd_type  out  3  constant 3'b100 (cache line)
- rd_addr  out  32  {tag,index,0}
- rd_rdy  in  1  bus accepts read request
- ret_valid  in  1  refill beat valid
- ret_last  in  1  last refill beat
- ret_data  in  64  refill beat data
- wr_req  out  1  line write-back request
- wr_type  out  3  constant 3'b100
- wr_addr  out  32  {victim tag,index,0}
- wr_wstrb  out  8  constant 8'hFF
- wr_data  out  8*2^OFFSET_BITS  whole victim line, beat 0 in LSBs
- wr_rdy  in  1  bus can take write-back

## Operation
- Storage per way per set: valid, dirty, tag, line data; per set a log2(WAYS)-bit round-robin pointer.
- States: IDLE, LOOKUP, WRITEBACK, MISS, REFILL.
- IDLE: addr_ok=1. valid&&addr_ok latches op/index/tag/offset/wstrb/wdata; -> LOOKUP.
- LOOKUP: hit = any way valid with equal tag (at most one). Read hit: data_ok=1, rdata = doubleword offset[OFFSET_BITS-1:3] of hit line; -> IDLE. Write hit: bytes with wstrb=1 merged into that doubleword, dirty set, data_ok=1; -> IDLE. Miss: victim = lowest-numbered invalid way, else way at round-robin pointer; victim valid&&dirty -> WRITEBACK, else -> MISS.
- WRITEBACK: wr_req = wr_rdy (never raised before wr_rdy seen high); wr_addr/wr_data from victim; transfer completes in that cycle; -> MISS.
- MISS: rd_req=1, held with stable rd_addr until rd_rdy; rd_req&&rd_rdy -> REFILL, beat counter cleared.
- REFILL: each ret_valid writes ret_data into victim line at beat counter, counter increments. Beat with ret_last: victim tag written, valid=1, dirty=0, round-robin pointer of set incremented mod WAYS only if victim was chosen by pointer; -> LOOKUP (replay, now hits; write miss merges on replay).
- ret_valid outside REFILL ignored. ret_last before BEATS beats: line marked valid as is. Extra beats after ret_last ignored.
- Hits do not touch the pointer.

## Timing
- Reset (rst high at an edge): state IDLE, all valid/dirty/pointers cleared. While rst high and the cycle after it, outputs: addr_ok=0 during rst then 1, data_ok=0, rdata=0, rd_req=0, wr_req=0. Data arrays not cleared.
- Reset mid-operation: same as above; in-flight request dropped, no data_ok; partly refilled line stays invalid.
- Hit latency: accept cycle N, data_ok cycle N+1; next accept earliest N+2.
- Clean miss: accept N; rd_req from N+2; handshake at M; beats; ret_last at L; data_ok L+1.
- Dirty miss adds one cycle when wr_rdy is high at N+2.
- addr_ok and data_ok never high in the same cycle.

## Test plan
- Defaults. Reset, then read tag/index/offset for 0x80000018 -> rd_req with rd_addr 0x80000010; return 0x1111111111111111, 0x2222222222222222 (ret_last) -> data_ok, rdata 0x2222222222222222.
- Write 0x80000018 wdata 0xAAAABBBBCCCCDDDD wstrb 0x0F -> data_ok one cycle after accept, no bus traffic; read it back -> 0x22222222CCCCDDDD.
- WAYS=2: dirty line 0x80000010, clean fill 0x80000810 (same set), read 0x80001010 -> wr_req, wr_addr 0x80000010, wr_data upper doubleword 0x22222222CCCCDDDD, then rd_req 0x80001010; 0x80000810 still hits.
- rd_rdy low 5 cycles -> rd_req high and rd_addr stable throughout; wr_rdy low -> wr_req stays 0.
- rst pulsed after first refill beat -> no data_ok; re-read same address misses again and refills.
- WAYS=1 and OFFSET_BITS=5: 4-beat refill, rdata for offset 0x18 = fourth beat.
